// File: rtl/tilelink_ul_a_arbiter_if.sv
// Bundle of every TL-UL signal seen by tilelink_ul_a_arbiter.
//   m_a_* / m_d_* : two upstream masters, lane i at bits [(i+1)*W-1 : i*W]
//                   (m_d_* fields are a single copy broadcast to both lanes)
//   s_a_* / s_d_* : one downstream slave, source widened by one lane bit
// Modports:
//   slave  : the arbiter's view (slave to the masters, drives the downstream)
//   master : the surrounding environment's view (masters plus slave model)
interface tilelink_ul_a_arbiter_if #(
  parameter int unsigned TL_ADDR_WIDTH   = 64,
  parameter int unsigned TL_DATA_WIDTH   = 64,
  parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int unsigned TL_SOURCE_WIDTH = 3,
  parameter int unsigned TL_SINK_WIDTH   = 3,
  parameter int unsigned TL_OPCODE_WIDTH = 3,
  parameter int unsigned TL_PARAM_WIDTH  = 3,
  parameter int unsigned TL_SIZE_WIDTH   = 8
);
  // Upstream A
  logic [1:0]                   m_a_valid;
  logic [1:0]                   m_a_ready;
  logic [2*TL_OPCODE_WIDTH-1:0] m_a_opcode;
  logic [2*TL_PARAM_WIDTH-1:0]  m_a_param;
  logic [2*TL_SIZE_WIDTH-1:0]   m_a_size;
  logic [2*TL_SOURCE_WIDTH-1:0] m_a_source;
  logic [2*TL_ADDR_WIDTH-1:0]   m_a_address;
  logic [2*TL_STRB_WIDTH-1:0]   m_a_mask;
  logic [2*TL_DATA_WIDTH-1:0]   m_a_data;
  // Downstream A
  logic                         s_a_valid;
  logic                         s_a_ready;
  logic [TL_OPCODE_WIDTH-1:0]   s_a_opcode;
  logic [TL_PARAM_WIDTH-1:0]    s_a_param;
  logic [TL_SIZE_WIDTH-1:0]     s_a_size;
  logic [TL_SOURCE_WIDTH:0]     s_a_source;
  logic [TL_ADDR_WIDTH-1:0]     s_a_address;
  logic [TL_STRB_WIDTH-1:0]     s_a_mask;
  logic [TL_DATA_WIDTH-1:0]     s_a_data;
  // Downstream D
  logic                         s_d_valid;
  logic                         s_d_ready;
  logic [TL_OPCODE_WIDTH-1:0]   s_d_opcode;
  logic [TL_PARAM_WIDTH-1:0]    s_d_param;
  logic [TL_SIZE_WIDTH-1:0]     s_d_size;
  logic [TL_SINK_WIDTH-1:0]     s_d_sink;
  logic [TL_SOURCE_WIDTH:0]     s_d_source;
  logic [TL_DATA_WIDTH-1:0]     s_d_data;
  logic                         s_d_error;
  // Upstream D
  logic [1:0]                   m_d_valid;
  logic [1:0]                   m_d_ready;
  logic [TL_OPCODE_WIDTH-1:0]   m_d_opcode;
  logic [TL_PARAM_WIDTH-1:0]    m_d_param;
  logic [TL_SIZE_WIDTH-1:0]     m_d_size;
  logic [TL_SINK_WIDTH-1:0]     m_d_sink;
  logic [TL_SOURCE_WIDTH-1:0]   m_d_source;
  logic [TL_DATA_WIDTH-1:0]     m_d_data;
  logic                         m_d_error;

  modport slave (
    input  m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask,
    input  m_a_data,
    output m_a_ready,
    output s_a_valid, s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask,
    output s_a_data,
    input  s_a_ready,
    input  s_d_valid, s_d_opcode, s_d_param, s_d_size, s_d_sink, s_d_source, s_d_data,
    input  s_d_error,
    output s_d_ready,
    output m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_sink, m_d_source, m_d_data,
    output m_d_error,
    input  m_d_ready
  );

  modport master (
    output m_a_valid, m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask,
    output m_a_data,
    input  m_a_ready,
    input  s_a_valid, s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask,
    input  s_a_data,
    output s_a_ready,
    output s_d_valid, s_d_opcode, s_d_param, s_d_size, s_d_sink, s_d_source, s_d_data,
    output s_d_error,
    input  s_d_ready,
    input  m_d_valid, m_d_opcode, m_d_param, m_d_size, m_d_sink, m_d_source, m_d_data,
    input  m_d_error,
    output m_d_ready
  );
endinterface

// File: rtl/tilelink_ul_a_arbiter.sv
// Two-master TL-UL arbiter in front of a single slow TL-UL slave.
// A channel: one beat granted per IDLE->HOLD pass; the winning lane is tagged in the
// MSB of s_a_source. D channel: routed back combinationally by that MSB.
// An outstanding counter blocks new grants once MAX_OUTSTANDING beats are in flight.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : tilelink_ul_a_arbiter_if.slave (all m_* and s_* channels)
// Build option: define TL_UL_ARB_RR_EN for round-robin tie-breaking; otherwise lane 0
// always wins ties (fixed priority).
module tilelink_ul_a_arbiter #(
  parameter int unsigned TL_ADDR_WIDTH   = 64,
  parameter int unsigned TL_DATA_WIDTH   = 64,
  parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int unsigned TL_SOURCE_WIDTH = 3,
  parameter int unsigned TL_SINK_WIDTH   = 3,
  parameter int unsigned TL_OPCODE_WIDTH = 3,
  parameter int unsigned TL_PARAM_WIDTH  = 3,
  parameter int unsigned TL_SIZE_WIDTH   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                     clk,
  input logic                     reset,
  tilelink_ul_a_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic [CntW-1:0] count_q, count_d;

  logic       a_fire;
  logic       d_fire;
  logic       d_lane;
  logic       can_issue;
  logic [1:0] a_ready;

  assign d_lane    = bus.s_d_source[TL_SOURCE_WIDTH];
  assign d_fire    = bus.s_d_valid & bus.m_d_ready[d_lane];
  assign a_fire    = (state_q == StHold) & bus.s_a_ready;
  // Uses the registered count, so a D fire this cycle only unblocks next cycle.
  assign can_issue = (count_q < CntW'(MAX_OUTSTANDING));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if ((|bus.m_a_valid) && can_issue) begin
          state_d = StHold;
          grant_d = (&bus.m_a_valid) ? prio_q : bus.m_a_valid[1];
        end
      end
      StHold: begin
        if (bus.s_a_ready) begin
          state_d = StIdle;
`ifdef TL_UL_ARB_RR_EN
          prio_d  = ~grant_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturates at 0 so a stray D response cannot wrap the counter.
  always_comb begin
    count_d = count_q;
    if (a_fire && !d_fire) begin
      count_d = count_q + CntW'(1);
    end else if (!a_fire && d_fire && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      count_q <= count_d;
    end
  end

  // A channel: valid straight from the state register, fields muxed by the frozen grant.
  always_comb begin
    a_ready = 2'b00;
    if (state_q == StHold) begin
      a_ready[grant_q] = bus.s_a_ready;
    end
  end

  assign bus.m_a_ready   = a_ready;
  assign bus.s_a_valid   = (state_q == StHold);
  assign bus.s_a_opcode  = bus.m_a_opcode[grant_q * TL_OPCODE_WIDTH +: TL_OPCODE_WIDTH];
  assign bus.s_a_param   = bus.m_a_param[grant_q * TL_PARAM_WIDTH +: TL_PARAM_WIDTH];
  assign bus.s_a_size    = bus.m_a_size[grant_q * TL_SIZE_WIDTH +: TL_SIZE_WIDTH];
  assign bus.s_a_source  = {grant_q,
                            bus.m_a_source[grant_q * TL_SOURCE_WIDTH +: TL_SOURCE_WIDTH]};
  assign bus.s_a_address = bus.m_a_address[grant_q * TL_ADDR_WIDTH +: TL_ADDR_WIDTH];
  assign bus.s_a_mask    = bus.m_a_mask[grant_q * TL_STRB_WIDTH +: TL_STRB_WIDTH];
  assign bus.s_a_data    = bus.m_a_data[grant_q * TL_DATA_WIDTH +: TL_DATA_WIDTH];

  // D channel: purely combinational steering by the lane tag.
  assign bus.m_d_valid  = d_lane ? {bus.s_d_valid, 1'b0} : {1'b0, bus.s_d_valid};
  assign bus.s_d_ready  = bus.m_d_ready[d_lane];
  assign bus.m_d_opcode = bus.s_d_opcode[TL_OPCODE_WIDTH-1:0];
  assign bus.m_d_param  = bus.s_d_param[TL_PARAM_WIDTH-1:0];
  assign bus.m_d_size   = bus.s_d_size[TL_SIZE_WIDTH-1:0];
  assign bus.m_d_sink   = bus.s_d_sink[TL_SINK_WIDTH-1:0];
  assign bus.m_d_source = bus.s_d_source[TL_SOURCE_WIDTH-1:0];
  assign bus.m_d_data   = bus.s_d_data[TL_DATA_WIDTH-1:0];
  assign bus.m_d_error  = bus.s_d_error;

endmodule

// File: tb/tb_tilelink_ul_a_arbiter.sv
// Directed bench for tilelink_ul_a_arbiter (instantiated with MAX_OUTSTANDING = 2).
// Inputs change just after the falling edge; outputs are sampled 1-3 time units later.
module tb_tilelink_ul_a_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errs;

  tilelink_ul_a_arbiter_if bus ();

  tilelink_ul_a_arbiter #(
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic exp_lane;
    int   w;
    n_checks = 0;
    n_errs   = 0;

    // Lane 0: Get, source 3'b010. Lane 1: PutFull, source 3'b101.
    bus.m_a_valid   = 2'b11;
    bus.m_a_opcode  = {3'd0, 3'd4};
    bus.m_a_param   = '0;
    bus.m_a_size    = {8'd2, 8'd3};
    bus.m_a_source  = {3'b101, 3'b010};
    bus.m_a_address = {64'h2000, 64'h1000};
    bus.m_a_mask    = {8'h0F, 8'hFF};
    bus.m_a_data    = {64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0001};
    bus.s_a_ready   = 1'b1;
    bus.s_d_valid   = 1'b0;
    bus.s_d_opcode  = 3'd1;
    bus.s_d_param   = '0;
    bus.s_d_size    = 8'd3;
    bus.s_d_sink    = 3'd6;
    bus.s_d_source  = '0;
    bus.s_d_data    = 64'hD0D0_1234_5678_D0D0;
    bus.s_d_error   = 1'b0;
    bus.m_d_ready   = 2'b00;
    reset           = 1'b0;

    // Reset state with both lanes already requesting
    step(); step(); #1;
    check("rst_s_a_valid", 64'(bus.s_a_valid), 64'd0);
    check("rst_m_a_ready", 64'(bus.m_a_ready), 64'd0);
    step(); reset = 1'b1; #1;
    check("rel_idle", 64'(bus.s_a_valid), 64'd0);

    // Tie goes to lane 0 first
    step(); #1;
    check("t1_valid0",  64'(bus.s_a_valid),  64'd1);
    check("t1_src0",    64'(bus.s_a_source), 64'h2);
    check("t1_addr0",   bus.s_a_address,     64'h1000);
    check("t1_op0",     64'(bus.s_a_opcode), 64'd4);
    check("t1_ready0",  64'(bus.m_a_ready),  64'b01);
    step();
    bus.m_a_valid = 2'b10; #1;
    check("t1_bubble",  64'(bus.s_a_valid),  64'd0);
    step(); #1;
    check("t1_valid1",  64'(bus.s_a_valid),  64'd1);
    check("t1_src1",    64'(bus.s_a_source), 64'hD);
    check("t1_addr1",   bus.s_a_address,     64'h2000);
    check("t1_data1",   bus.s_a_data,        64'hBBBB_0000_BBBB_0001);
    check("t1_mask1",   64'(bus.s_a_mask),   64'h0F);
    check("t1_ready1",  64'(bus.m_a_ready),  64'b10);

    // Two beats in flight: lane 0 must stay blocked
    step();
    bus.m_a_valid = 2'b01; #1;
    check("blk_bubble", 64'(bus.s_a_valid), 64'd0);
    repeat (3) begin
      step(); #1;
      check("blk_valid", 64'(bus.s_a_valid), 64'd0);
    end

    // D response to lane 1
    bus.s_d_valid  = 1'b1;
    bus.s_d_source = 4'b1101;
    bus.m_d_ready  = 2'b10; #1;
    check("d1_valid",  64'(bus.m_d_valid),  64'b10);
    check("d1_source", 64'(bus.m_d_source), 64'b101);
    check("d1_data",   bus.m_d_data,        64'hD0D0_1234_5678_D0D0);
    check("d1_sink",   64'(bus.m_d_sink),   64'd6);
    check("d1_ready",  64'(bus.s_d_ready),  64'd1);
    bus.m_d_ready = 2'b01; #1;
    check("d1_ready_lo", 64'(bus.s_d_ready), 64'd0);
    bus.m_d_ready = 2'b10; #1;
    check("d1_ready_hi", 64'(bus.s_d_ready), 64'd1);
    step();
    bus.s_d_valid = 1'b0; #1;
    check("d_same_cycle_block", 64'(bus.s_a_valid), 64'd0);
    step(); #1;
    check("d_unblock",     64'(bus.s_a_valid),  64'd1);
    check("d_unblock_src", 64'(bus.s_a_source), 64'h2);

    // A fire and D fire together (lane 0 response), count must stay at 1
    bus.s_d_valid  = 1'b1;
    bus.s_d_source = 4'b0011;
    bus.m_d_ready  = 2'b01; #1;
    check("d0_valid",  64'(bus.m_d_valid),  64'b01);
    check("d0_source", 64'(bus.m_d_source), 64'b011);
    check("d0_ready",  64'(bus.s_d_ready),  64'd1);
    step();
    bus.s_d_valid = 1'b0;
    bus.m_a_valid = 2'b10; #1;
    check("both_bubble", 64'(bus.s_a_valid), 64'd0);
    step(); #1;
    check("cnt_grant",     64'(bus.s_a_valid),  64'd1);
    check("cnt_grant_src", 64'(bus.s_a_source), 64'hD);
    step();
    repeat (2) begin
      step(); #1;
      check("cnt_full", 64'(bus.s_a_valid), 64'd0);
    end

    // Back-to-back ties with the slave draining D every cycle
    bus.m_a_valid = 2'b00;
    reset = 1'b0;
    step();
    reset          = 1'b1;
    bus.m_a_valid  = 2'b11;
    bus.s_a_ready  = 1'b1;
    bus.s_d_valid  = 1'b1;
    bus.s_d_source = 4'b0000;
    bus.m_d_ready  = 2'b11;
    for (int i = 0; i < 6; i++) begin
`ifdef TL_UL_ARB_RR_EN
      exp_lane = i[0];
`else
      exp_lane = 1'b0;
`endif
      w = 0;
      #1;
      while (!bus.s_a_valid && w < 4) begin
        step(); #1;
        w++;
      end
      check("burst_valid", 64'(bus.s_a_valid),     64'd1);
      check("burst_lane",  64'(bus.s_a_source[3]), 64'(exp_lane));
      step();
    end
    bus.m_a_valid = 2'b00;
    bus.s_d_valid = 1'b0;
    bus.s_a_ready = 1'b0;
    step();

    // Lane 1 stalled; lane 0 arrives mid-stall and must not steal the grant
    bus.m_a_valid = 2'b10;
    step(); #1;
    check("stall_valid", 64'(bus.s_a_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.m_a_valid = 2'b11;
      #1;
      check("stall_src",   64'(bus.s_a_source), 64'hD);
      check("stall_addr",  bus.s_a_address,     64'h2000);
      check("stall_ready", 64'(bus.m_a_ready),  64'b00);
      step();
    end
    bus.s_a_ready = 1'b1; #1;
    check("stall_go_ready", 64'(bus.m_a_ready),  64'b10);
    check("stall_go_src",   64'(bus.s_a_source), 64'hD);
    step();
    bus.m_a_valid = 2'b01; #1;
    check("stall_bubble", 64'(bus.s_a_valid), 64'd0);
    step(); #1;
    check("after_stall_valid", 64'(bus.s_a_valid),  64'd1);
    check("after_stall_src",   64'(bus.s_a_source), 64'h2);

    // Reset while holding lane 0 (count is 1 at this point)
    bus.s_a_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("hold_rst_valid", 64'(bus.s_a_valid), 64'd0);
    check("hold_rst_ready", 64'(bus.m_a_ready), 64'd0);
    step();
    reset         = 1'b1;
    bus.s_a_ready = 1'b1; #1;
    check("hold_rel_idle", 64'(bus.s_a_valid), 64'd0);
    step(); #1;
    check("rst_cnt_first", 64'(bus.s_a_valid), 64'd1);
    step();
    step(); #1;
    check("rst_cnt_clear", 64'(bus.s_a_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
